execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage RV32IM pipeline. It consumes the decoded operands, immediate, destination and control byte held by the ID/EX pipeline register. It computes ALU, branch/jump and M-extension results and presents them to the EX/MEM boundary through a registered valid/ready output. Multiply and divide run on an iterative 32-step engine, and the block back-pressures the ID/EX register (`in_ready` low) while that engine is busy.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: kill the in-flight operation and the output register (branch redirect from a later stage).
- `in_valid` in 1: ID/EX holds a valid instruction.
- `in_ready` out 1: stage accepts this cycle. While low, ID/EX must hold.
- `pc`, `rs1_data`, `rs2_data`, `imm` in 32 each: operands from ID/EX.
- `rd` in 5: destination register.
- `alu_op` in 4: operation code, decoded as described under Operation.
- `control_unit_signal` in 8, bit meanings:
  - [0] B operand = `imm`
  - [1] reg_write
  - [2] mem_read
  - [3] mem_write
  - [4] branch
  - [5] jump
  - [6] muldiv
  - [7] A operand = `pc`
- `out_valid` out 1 / `out_ready` in 1: output handshake to EX/MEM.
- `out_result` out 32: ALU/muldiv result, or pc+4 for jumps.
- `out_rs2_data` out 32: store data.
- `out_rd` out 5; `out_control` out 8: registered copies of the inputs.
- `out_branch_taken` out 1; `out_branch_target` out 32.

## Operation
- Operands: A = ctrl[7] ? `pc` : `rs1_data`. B = ctrl[0] ? `imm` : `rs2_data`.
- `alu_op` encoding when ctrl[6]=0:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 EQ, 11 NE, 12 GE, 13 GEU (results 0/1), 14 PASS_B, 15 → 0
  - Shift amounts use B[4:0].
- Branch (ctrl[4]=1): `out_branch_taken` = ALU result[0]; target = `pc`+`imm`.
- Jump (ctrl[5]=1): taken = 1; `out_result` = `pc`+4.
  - Target is `pc`+`imm` if ctrl[7]=1 (JAL), else (`rs1_data`+`imm`) with bit 0 cleared (JALR).
- Muldiv (ctrl[6]=1): `alu_op[2:0]` selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Operands are always `rs1_data` and `rs2_data`.
- Muldiv algorithm:
  - Signed ops take operand magnitudes, then one final cycle applies the sign correction.
  - Multiply is 32 shift-add steps into a 64-bit product.
  - Divide is 32 restoring steps.
- Muldiv special cases:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV/REM of 0x80000000 by -1: quotient = 0x80000000, remainder = 0.
- State machine: IDLE → BUSY (32 iterations, counter 0..31) → FIX (sign correction; loads the output register) → IDLE.
- `in_ready` = (state==IDLE) && (!`out_valid` || `out_ready`).
- Accept = `in_valid` && `in_ready`. For a non-muldiv accept, all outputs are registered on the accept edge.
- `flush` has priority over everything else: state → IDLE, counter → 0, `out_valid` → 0. An accept in the same cycle as `flush` is dropped.
- Reset values:
  - `out_valid`, `out_branch_taken` = 0; all data and control outputs = 0.
  - State IDLE, so `in_ready` = 1 in the first cycle after reset (`out_valid`=0).

## Timing
- Non-muldiv: accepted on edge E, `out_valid` high after E (latency 1). Back-to-back accepts give throughput 1 per cycle while `out_ready`=1.
- Muldiv: accepted on edge E, then BUSY on edges E+1..E+32 and FIX on E+33. `out_valid` is high after E+33 (latency 34).
- `in_ready` is low from after E until after the output of FIX is consumed.
- `out_valid` and all output data stay stable until `out_valid` && `out_ready`. With no new accept in that cycle, `out_valid` drops on the following edge.
- Reset asserted mid-BUSY aborts the operation immediately, with no output.

## Test plan
- ADD, SUB, SRA, SLTU with `rs1_data`=0x80000000, `rs2_data`=1:
  - ADD → 0x80000001
  - SUB → 0x7FFFFFFF
  - SRA (B=1) → 0xC0000000
  - SLTU → 0
  - Each valid 1 cycle after accept, 4 back-to-back, `in_ready` stays 1.
- Branches:
  - BEQ (op 10) with equal operands, `pc`=0x100, `imm`=0x20 → taken=1, target 0x120.
  - JALR with `rs1_data`=0x203, `imm`=0 → target 0x202, `out_result` = `pc`+4.
- MUL/MULH of 0xFFFFFFFF × 0xFFFFFFFF:
  - MUL → 0x00000001; MULH → 0; MULHU → 0xFFFFFFFE.
  - `out_valid` exactly 34 cycles after accept; `in_ready`=0 throughout.
- Divide corner cases:
  - DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7.
  - DIV 0x80000000/−1 → 0x80000000; REM → 0.
  - DIV −7/2 → −3; REM → −1.
- `out_ready` held 0 for 5 cycles: the output holds constant, `in_ready`=0, and the next instruction is accepted only on the cycle `out_ready` returns to 1.
- Mid-operation aborts:
  - `flush` in BUSY iteration 10: `out_valid` never asserts and `in_ready` returns to 1 the next cycle.
  - Repeat with `rst_n` asserted low asynchronously: the same outcome, and all outputs read 0.

Source files
------------

// File: rtl/execute_stage.sv
// RV32IM execute stage: single-cycle ALU/branch/jump path plus a 32-step iterative
// multiply/divide engine, feeding a registered valid/ready output to EX/MEM.
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd,
    input  logic [3:0]      alu_op,
    input  logic [7:0]      control_unit_signal,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic [7:0]      out_control,
    output logic            out_branch_taken,
    output logic [XLEN-1:0] out_branch_target
);

    localparam int DW = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

    state_t          state, state_nxt;
    logic [4:0]      cnt_p0, cnt_nxt;

    // Engine operands and metadata, captured on a muldiv accept
    logic [DW-1:0]   prod_p0;
    logic [XLEN-1:0] opb_p0;
    logic [2:0]      md_op_p0;
    logic            a_neg_p0, b_neg_p0, div0_p0;
    logic [4:0]      md_rd_p0;
    logic [7:0]      md_ctrl_p0;
    logic [XLEN-1:0] md_rs2_p0;

    // Output register
    logic            vld_p1, taken_p1;
    logic [XLEN-1:0] res_p1, rs2_p1, tgt_p1;
    logic [4:0]      rd_p1;
    logic [7:0]      ctrl_p1;

    logic            accept, is_muldiv;
    logic [XLEN-1:0] op_a, op_b, alu_res, pc_imm, jalr_sum, pc_plus4;
    logic [XLEN-1:0] ex_result, ex_target, mag_a, mag_b;
    logic            ex_taken, sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [DW-1:0]   mul_next, div_next;

    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] a_s, b_s;
        logic [XLEN-1:0]        r;
        a_s = signed'(a);
        b_s = signed'(b);
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a << b[4:0];
            4'd3:    r = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            4'd4:    r = {{(XLEN-1){1'b0}}, (a < b)};
            4'd5:    r = a ^ b;
            4'd6:    r = a >> b[4:0];
            4'd7:    r = a_s >>> b[4:0];
            4'd8:    r = a | b;
            4'd9:    r = a & b;
            4'd10:   r = {{(XLEN-1){1'b0}}, (a == b)};
            4'd11:   r = {{(XLEN-1){1'b0}}, (a != b)};
            4'd12:   r = {{(XLEN-1){1'b0}}, (a_s >= b_s)};
            4'd13:   r = {{(XLEN-1){1'b0}}, (a >= b)};
            4'd14:   r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mag_f(input logic [XLEN-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // Applies the deferred sign correction to the unsigned engine result
    function automatic logic [XLEN-1:0] sign_fix(input logic [2:0] op,
                                                 input logic [DW-1:0] p,
                                                 input logic an,
                                                 input logic bn,
                                                 input logic dz);
        logic [DW-1:0]   sp;
        logic [XLEN-1:0] q, r, res;
        sp = (an ^ bn) ? (~p + 1'b1) : p;
        q  = (an ^ bn) ? (~p[XLEN-1:0] + 1'b1) : p[XLEN-1:0];
        r  = an ? (~p[DW-1:XLEN] + 1'b1) : p[DW-1:XLEN];
        case (op)
            3'd0:          res = sp[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          res = sp[DW-1:XLEN];
            3'd4, 3'd5:    res = dz ? '1 : q;
            default:       res = r;
        endcase
        return res;
    endfunction

    assign is_muldiv = control_unit_signal[6];
    assign in_ready  = (state == S_IDLE) && (!vld_p1 || out_ready);
    assign accept    = in_valid && in_ready && !flush;

    assign op_a     = control_unit_signal[7] ? pc : rs1_data;
    assign op_b     = control_unit_signal[0] ? imm : rs2_data;
    assign alu_res  = alu_f(alu_op, op_a, op_b);
    assign pc_imm   = pc + imm;
    assign jalr_sum = rs1_data + imm;
    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        ex_result = alu_res;
        ex_taken  = 1'b0;
        ex_target = pc_imm;
        if (control_unit_signal[5]) begin
            ex_result = pc_plus4;
            ex_taken  = 1'b1;
            ex_target = control_unit_signal[7] ? pc_imm : {jalr_sum[XLEN-1:1], 1'b0};
        end else if (control_unit_signal[4]) begin
            ex_taken = alu_res[0];
        end
    end

    // Signedness per muldiv op: MUL/MULH/MULHSU/DIV/REM sign A; MUL/MULH/DIV/REM sign B
    always_comb begin
        if (alu_op[2]) begin
            sgn_a = !alu_op[0];
            sgn_b = !alu_op[0];
        end else begin
            sgn_a = (alu_op[1:0] != 2'd3);
            sgn_b = !alu_op[1];
        end
    end

    assign a_neg = sgn_a && rs1_data[XLEN-1];
    assign b_neg = sgn_b && rs2_data[XLEN-1];
    assign mag_a = mag_f(rs1_data, a_neg);
    assign mag_b = mag_f(rs2_data, b_neg);

    // Multiply: {hi,lo} shifts right, hi accumulates the multiplicand when lo[0] is set.
    // Divide: {rem,quo} shifts left, restoring subtract of the divisor.
    assign mul_sum   = {1'b0, prod_p0[DW-1:XLEN]} + (prod_p0[0] ? {1'b0, opb_p0} : '0);
    assign mul_next  = {mul_sum, prod_p0[XLEN-1:1]};
    assign div_shift = {prod_p0[DW-1:XLEN], prod_p0[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_p0};
    assign div_next  = div_diff[XLEN]
                     ? {div_shift[XLEN-1:0], prod_p0[XLEN-2:0], 1'b0}
                     : {div_diff[XLEN-1:0],  prod_p0[XLEN-2:0], 1'b1};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_p0;
        if (flush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_muldiv) begin
                        state_nxt = S_BUSY;
                        cnt_nxt   = '0;
                    end
                end
                S_BUSY: begin
                    cnt_nxt = cnt_p0 + 5'd1;
                    if (cnt_p0 == 5'd31) state_nxt = S_FIX;
                end
                S_FIX:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt_p0 <= '0;
        end else begin
            state  <= state_nxt;
            cnt_p0 <= cnt_nxt;
        end
    end

    // ---- p0: iterative muldiv engine ----
    always_ff @(posedge clk) begin
        if (accept && is_muldiv) begin
            prod_p0    <= {{XLEN{1'b0}}, mag_a};
            opb_p0     <= mag_b;
            md_op_p0   <= alu_op[2:0];
            a_neg_p0   <= a_neg;
            b_neg_p0   <= b_neg;
            div0_p0    <= (rs2_data == '0);
            md_rd_p0   <= rd;
            md_ctrl_p0 <= control_unit_signal;
            md_rs2_p0  <= rs2_data;
        end else if (state == S_BUSY) begin
            prod_p0 <= md_op_p0[2] ? div_next : mul_next;
        end
    end

    // ---- p1: EX/MEM output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            taken_p1 <= 1'b0;
            res_p1   <= '0;
            rs2_p1   <= '0;
            tgt_p1   <= '0;
            rd_p1    <= '0;
            ctrl_p1  <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept && !is_muldiv) begin
            vld_p1   <= 1'b1;
            taken_p1 <= ex_taken;
            res_p1   <= ex_result;
            rs2_p1   <= rs2_data;
            tgt_p1   <= ex_target;
            rd_p1    <= rd;
            ctrl_p1  <= control_unit_signal;
        end else if (state == S_FIX) begin
            vld_p1   <= 1'b1;
            taken_p1 <= 1'b0;
            res_p1   <= sign_fix(md_op_p0, prod_p0, a_neg_p0, b_neg_p0, div0_p0);
            rs2_p1   <= md_rs2_p0;
            tgt_p1   <= '0;
            rd_p1    <= md_rd_p0;
            ctrl_p1  <= md_ctrl_p0;
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid         = vld_p1;
    assign out_result        = res_p1;
    assign out_rs2_data      = rs2_p1;
    assign out_rd            = rd_p1;
    assign out_control       = ctrl_p1;
    assign out_branch_taken  = taken_p1;
    assign out_branch_target = tgt_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected results,
// a monitor pops and compares on every output handshake.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [7:0]  control_unit_signal;
    logic [31:0] out_result, out_rs2_data, out_branch_target;
    logic [4:0]  out_rd;
    logic [7:0]  out_control;
    logic        out_branch_taken;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rs2;
        logic [31:0] tgt;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic        tk;
        bit          chk_br;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
        .alu_op(alu_op), .control_unit_signal(control_unit_signal),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_control(out_control),
        .out_branch_taken(out_branch_taken), .out_branch_target(out_branch_target)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h expected no output", out_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("rs2_data", out_rs2_data, e.rs2);
                chk("control", {24'd0, out_control}, {24'd0, e.ctrl});
                if (e.chk_br) begin
                    chk("taken", {31'd0, out_branch_taken}, {31'd0, e.tk});
                    chk("target", out_branch_target, e.tgt);
                end
            end
        end
    end

    task automatic set_in(input logic [31:0] p, r1, r2, im, input logic [4:0] d,
                          input logic [3:0] op, input logic [7:0] ct);
        pc = p; rs1_data = r1; rs2_data = r2; imm = im; rd = d;
        alu_op = op; control_unit_signal = ct; in_valid = 1'b1;
    endtask

    task automatic issue(input logic [31:0] p, r1, r2, im, input logic [4:0] d,
                         input logic [3:0] op, input logic [7:0] ct,
                         input logic [31:0] eres, input logic etk, input logic [31:0] etgt,
                         input bit push, output int waited);
        exp_t e;
        set_in(p, r1, r2, im, d, op, ct);
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected accept", waited);
                in_valid = 1'b0;
                return;
            end
        end
        if (push) begin
            e.res = eres; e.rs2 = r2; e.tgt = etgt; e.rd = d; e.ctrl = ct;
            e.tk = etk; e.chk_br = !ct[6];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, n;
        bit bad;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; rs1_data = '0; rs2_data = '0; imm = '0; rd = '0;
        alu_op = '0; control_unit_signal = '0;
        #22;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_result", out_result, 0);
        chk("rst_taken", {31'd0, out_branch_taken}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 1);

        // Back-to-back ALU ops
        issue(0, 32'h8000_0000, 1, 0, 5'd1, 4'd0, 8'h02, 32'h8000_0001, 0, 0, 1, w);
        chk("b2b_wait_add", w, 0);
        issue(0, 32'h8000_0000, 1, 0, 5'd2, 4'd1, 8'h02, 32'h7FFF_FFFF, 0, 0, 1, w);
        chk("b2b_wait_sub", w, 0);
        issue(0, 32'h8000_0000, 1, 0, 5'd3, 4'd7, 8'h02, 32'hC000_0000, 0, 0, 1, w);
        chk("b2b_wait_sra", w, 0);
        issue(0, 32'h8000_0000, 1, 0, 5'd4, 4'd4, 8'h02, 32'h0000_0000, 0, 0, 1, w);
        chk("b2b_wait_sltu", w, 0);
        issue(0, 32'hF0F0_F0F0, 3, 32'hFF, 5'd5, 4'd5, 8'h03, 32'hF0F0_F00F, 0, 32'hFF, 1, w);

        // Branches and jumps
        issue(32'h100, 5, 5, 32'h20, 5'd0, 4'd10, 8'h10, 1, 1, 32'h120, 1, w);
        issue(32'h100, 5, 6, 32'h20, 5'd0, 4'd10, 8'h10, 0, 0, 32'h120, 1, w);
        issue(32'h400, 32'h203, 0, 0, 5'd6, 4'd0, 8'h22, 32'h404, 1, 32'h202, 1, w);
        issue(32'h400, 0, 0, 32'h10, 5'd7, 4'd0, 8'hA2, 32'h404, 1, 32'h410, 1, w);

        // Multiply, with latency and back-pressure check on the first
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5'd8, 4'd0, 8'h42, 32'h1, 0, 0, 1, w);
        n = 0;
        bad = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!out_valid && in_ready) bad = 1;
        end
        chk("mul_latency_edges", n, 33);
        chk("mul_in_ready_low", {31'd0, bad}, 0);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5'd9, 4'd1, 8'h42, 32'h0, 0, 0, 1, w);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5'd10, 4'd3, 8'h42, 32'hFFFF_FFFE, 0, 0, 1, w);

        // Divide corner cases
        issue(0, 7, 0, 0, 5'd11, 4'd4, 8'h42, 32'hFFFF_FFFF, 0, 0, 1, w);
        issue(0, 7, 0, 0, 5'd12, 4'd6, 8'h42, 32'h7, 0, 0, 1, w);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 5'd13, 4'd4, 8'h42, 32'h8000_0000, 0, 0, 1, w);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 5'd14, 4'd6, 8'h42, 32'h0, 0, 0, 1, w);
        issue(0, 32'hFFFF_FFF9, 2, 0, 5'd15, 4'd4, 8'h42, 32'hFFFF_FFFD, 0, 0, 1, w);
        issue(0, 32'hFFFF_FFF9, 2, 0, 5'd16, 4'd6, 8'h42, 32'hFFFF_FFFF, 0, 0, 1, w);
        issue(0, 100, 7, 0, 5'd17, 4'd5, 8'h42, 32'hE, 0, 0, 1, w);
        issue(0, 100, 7, 0, 5'd18, 4'd7, 8'h42, 32'h2, 0, 0, 1, w);
        drain();

        // Output stall: result holds, next instruction waits for out_ready
        issue(0, 32'h10, 32'h20, 0, 5'd19, 4'd0, 8'h02, 32'h30, 0, 0, 1, w);
        out_ready = 1'b0;
        set_in(0, 32'h50, 32'h8, 0, 5'd20, 4'd1, 8'h02);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 1);
            chk("hold_result", out_result, 32'h30);
            chk("hold_in_ready", {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("ready_return_in_ready", {31'd0, in_ready}, 1);
        begin
            exp_t e;
            e.res = 32'h48; e.rs2 = 32'h8; e.tgt = 0; e.rd = 5'd20; e.ctrl = 8'h02;
            e.tk = 0; e.chk_br = 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accept_on_ready", out_result, 32'h48);
        drain();

        // Accept coinciding with flush is dropped
        set_in(0, 1, 2, 0, 5'd21, 4'd0, 8'h02);
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_drops_accept", {31'd0, out_valid}, 0);

        // Flush in BUSY iteration 10
        issue(0, 100, 7, 0, 5'd22, 4'd4, 8'h42, 0, 0, 0, 0, w);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", {31'd0, in_ready}, 1);
        chk("flush_out_valid", {31'd0, out_valid}, 0);
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) bad = 1;
        end
        chk("flush_no_output", {31'd0, bad}, 0);

        // Asynchronous reset in BUSY iteration 10
        chk("pre_reset_result", out_result, 32'h48);
        issue(0, 100, 7, 0, 5'd23, 4'd4, 8'h42, 0, 0, 0, 0, w);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", {31'd0, out_valid}, 0);
        chk("areset_result", out_result, 0);
        chk("areset_rs2", out_rs2_data, 0);
        chk("areset_rd", {27'd0, out_rd}, 0);
        chk("areset_control", {24'd0, out_control}, 0);
        chk("areset_taken", {31'd0, out_branch_taken}, 0);
        chk("areset_target", out_branch_target, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("areset_in_ready", {31'd0, in_ready}, 1);
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) bad = 1;
        end
        chk("areset_no_output", {31'd0, bad}, 0);
        chk("final_queue_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
